// File: rtl/product_bcd_scroller.sv
// Converts the multiplier's signed product to five BCD digits, one double-dabble step per clock.
// A saturating pointer selects which three digits, plus the sign, reach the 7-segment driver.
module product_bcd_scroller #(
   parameter int W_IN = 16,
   parameter int WIN  = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              start_i,
   input  logic [W_IN-1:0]   product_i,
   input  logic              scroll_left_i,
   input  logic              scroll_right_i,
   output logic              busy_o,
   output logic              valid_o,
   output logic              sign_o,
   output logic [4*WIN-1:0]  window_o,
   output logic [WIN-1:0]    blank_o,
   output logic [1:0]        pos_o
);

   localparam int ND = 5;
   localparam int BW = 4 * ND;
   localparam logic [3:0] LAST_CNT = 4'(W_IN - 1);
   localparam logic [1:0] POS_MAX  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [W_IN-1:0] mag_q, mag_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [BW-1:0]   dig_q, dig_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            sign_nx_q, sign_nx_d;
   logic            sign_q, sign_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;
   logic [1:0]      pos_q, pos_d;

   logic [W_IN-1:0] abs_s;
   logic [BW-1:0]   adj_s;
   logic [BW-1:0]   bcd_shift_s;
   logic [ND:0]     lz_s;

   // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
   function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < ND; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = b[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Magnitude and the next accumulator value for one conversion step.
   always_comb begin
      abs_s       = product_i[W_IN-1] ? (~product_i + {{(W_IN-1){1'b0}}, 1'b1}) : product_i;
      adj_s       = dabble_adjust(bcd_q);
      bcd_shift_s = {adj_s[BW-2:0], mag_q[W_IN-1]};
   end

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      bcd_d     = bcd_q;
      dig_d     = dig_q;
      cnt_d     = cnt_q;
      sign_nx_d = sign_nx_q;
      sign_d    = sign_q;
      busy_d    = busy_q;
      valid_d   = valid_q;
      pos_d     = pos_q;
      if (clr_i) begin
         state_d   = S_IDLE;
         mag_d     = '0;
         bcd_d     = '0;
         dig_d     = '0;
         cnt_d     = 4'd0;
         sign_nx_d = 1'b0;
         sign_d    = 1'b0;
         busy_d    = 1'b0;
         valid_d   = 1'b0;
         pos_d     = 2'd0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_d   = S_CONV;
                  mag_d     = abs_s;
                  bcd_d     = '0;
                  cnt_d     = 4'd0;
                  sign_nx_d = product_i[W_IN-1];
                  busy_d    = 1'b1;
                  valid_d   = 1'b0;
                  pos_d     = 2'd0;
               end else if (valid_q && scroll_left_i && !scroll_right_i) begin
                  pos_d = (pos_q == POS_MAX) ? POS_MAX : pos_q + 2'd1;
               end else if (valid_q && scroll_right_i && !scroll_left_i) begin
                  pos_d = (pos_q == 2'd0) ? 2'd0 : pos_q - 2'd1;
               end else begin
                  pos_d = pos_q;
               end
            end
            S_CONV: begin
               bcd_d = bcd_shift_s;
               mag_d = {mag_q[W_IN-2:0], 1'b0};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_CNT) begin
                  state_d = S_DONE;
                  dig_d   = bcd_shift_s;
                  sign_d  = sign_nx_q;
                  busy_d  = 1'b0;
                  valid_d = 1'b1;
               end else begin
                  state_d = S_CONV;
               end
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         mag_q     <= '0;
         bcd_q     <= '0;
         dig_q     <= '0;
         cnt_q     <= 4'd0;
         sign_nx_q <= 1'b0;
         sign_q    <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         pos_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         mag_q     <= mag_d;
         bcd_q     <= bcd_d;
         dig_q     <= dig_d;
         cnt_q     <= cnt_d;
         sign_nx_q <= sign_nx_d;
         sign_q    <= sign_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         pos_q     <= pos_d;
      end
   end

   // lz_s[k] marks digit k and everything above it as zero; the units digit always shows.
   always_comb begin
      lz_s[ND] = 1'b1;
      for (int k = ND - 1; k >= 1; k--) begin
         lz_s[k] = lz_s[k+1] & (dig_q[4*k +: 4] == 4'd0);
      end
      lz_s[0] = 1'b0;
   end

   // Window and blank selection from the scroll position.
   always_comb begin
      case (pos_q)
         2'd0: begin
            window_o = dig_q[11:0];
            blank_o  = lz_s[2:0];
         end
         2'd1: begin
            window_o = dig_q[15:4];
            blank_o  = lz_s[3:1];
         end
         2'd2: begin
            window_o = dig_q[19:8];
            blank_o  = lz_s[4:2];
         end
         default: begin
            window_o = dig_q[11:0];
            blank_o  = lz_s[2:0];
         end
      endcase
   end

   assign busy_o  = busy_q;
   assign valid_o = valid_q;
   assign sign_o  = sign_q;
   assign pos_o   = pos_q;

endmodule

// File: tb/tb_product_bcd_scroller.sv
// Directed and randomized bench for product_bcd_scroller against an arithmetic decimal model.
module tb_product_bcd_scroller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        start;
   logic [15:0] product;
   logic        scroll_left;
   logic        scroll_right;
   logic        busy;
   logic        valid;
   logic        sign;
   logic [11:0] window;
   logic [2:0]  blank;
   logic [1:0]  pos;

   int checks   = 0;
   int failures = 0;

   int m_mag  = 0;
   int m_sign = 0;
   int m_pos  = 0;

   product_bcd_scroller dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clr_i          (clr),
      .start_i        (start),
      .product_i      (product),
      .scroll_left_i  (scroll_left),
      .scroll_right_i (scroll_right),
      .busy_o         (busy),
      .valid_o        (valid),
      .sign_o         (sign),
      .window_o       (window),
      .blank_o        (blank),
      .pos_o          (pos)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   function automatic int digit(input int m, input int k);
      return (m / pow10(k)) % 10;
   endfunction

   function automatic int exp_window(input int m, input int p);
      return (digit(m, p + 2) << 8) | (digit(m, p + 1) << 4) | digit(m, p);
   endfunction

   function automatic int exp_blank(input int m, input int p);
      int b = 0;
      for (int j = 0; j < 3; j++) begin
         if ((p + j) != 0 && m < pow10(p + j)) b = b | (1 << j);
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_view(input string tag);
      chk({tag, "_valid"},  32'(valid),  32'd1);
      chk({tag, "_pos"},    32'(pos),    32'(m_pos));
      chk({tag, "_window"}, 32'(window), 32'(exp_window(m_mag, m_pos)));
      chk({tag, "_blank"},  32'(blank),  32'(exp_blank(m_mag, m_pos)));
      chk({tag, "_sign"},   32'(sign),   32'(m_sign));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy"},   32'(busy),   32'd0);
      chk({tag, "_valid"},  32'(valid),  32'd0);
      chk({tag, "_sign"},   32'(sign),   32'd0);
      chk({tag, "_window"}, 32'(window), 32'h000);
      chk({tag, "_blank"},  32'(blank),  32'b110);
      chk({tag, "_pos"},    32'(pos),    32'd0);
   endtask

   // Start a conversion; optionally inject a second start and a scroll in the middle.
   task automatic run_conv(input string tag, input logic [15:0] p, input bit inject, input logic [15:0] other);
      int sp;
      @(negedge clk);
      start   = 1'b1;
      product = p;
      @(negedge clk);
      start   = 1'b0;
      product = 16'($urandom);
      chk({tag, "_busy_e0"},  32'(busy),  32'd1);
      chk({tag, "_valid_e0"}, 32'(valid), 32'd0);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (inject && i == 5) begin
            start       = 1'b1;
            product     = other;
            scroll_left = 1'b1;
         end else if (inject && i == 6) begin
            start       = 1'b0;
            scroll_left = 1'b0;
         end
         if (i == 15) begin
            chk({tag, "_busy_e15"},  32'(busy),  32'd1);
            chk({tag, "_valid_e15"}, 32'(valid), 32'd0);
         end
      end
      @(negedge clk);
      chk({tag, "_busy_e16"}, 32'(busy), 32'd0);
      sp     = int'($signed(p));
      m_mag  = (sp < 0) ? -sp : sp;
      m_sign = (sp < 0) ? 1 : 0;
      m_pos  = 0;
      check_view({tag, "_done"});
   endtask

   // One scroll pulse: l/r select the buttons; the model saturates at 0 and 2.
   task automatic scroll(input string tag, input bit l, input bit r);
      @(negedge clk);
      scroll_left  = l;
      scroll_right = r;
      @(negedge clk);
      scroll_left  = 1'b0;
      scroll_right = 1'b0;
      if (l && !r && m_pos < 2) m_pos++;
      if (r && !l && m_pos > 0) m_pos--;
      check_view(tag);
   endtask

   initial begin
      logic [15:0] rp;
      rst_n        = 1'b0;
      clr          = 1'b0;
      start        = 1'b0;
      product      = 16'd0;
      scroll_left  = 1'b0;
      scroll_right = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      run_conv("t1", 16'd1234, 1'b0, 16'd0);
      scroll("t1_left", 1'b1, 1'b0);

      run_conv("t2", 16'hFF38, 1'b0, 16'd0);
      scroll("t2_left1", 1'b1, 1'b0);
      scroll("t2_left2", 1'b1, 1'b0);
      scroll("t2_left3", 1'b1, 1'b0);
      scroll("t2_both", 1'b1, 1'b1);
      scroll("t2_right", 1'b0, 1'b1);

      run_conv("t3", 16'h8000, 1'b0, 16'd0);
      scroll("t3_left1", 1'b1, 1'b0);
      scroll("t3_left2", 1'b1, 1'b0);

      run_conv("t4", 16'd0, 1'b0, 16'd0);
      scroll("t4_right", 1'b0, 1'b1);

      run_conv("t5", 16'd4321, 1'b1, 16'd999);

      for (int n = 0; n < 12; n++) begin
         rp = 16'($urandom) >> $urandom_range(0, 12);
         if ($urandom_range(0, 1) == 1) rp = ~rp + 16'd1;
         run_conv("rnd", rp, 1'b0, 16'd0);
         for (int s = 0; s < 4; s++) begin
            scroll("rnd_scroll", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end

      run_conv("t6a", 16'hD8F1, 1'b0, 16'd0);
      scroll("t6a_left", 1'b1, 1'b0);
      @(negedge clk);
      start   = 1'b1;
      product = 16'd7777;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_state("t6_async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      run_conv("t6b", 16'hF000, 1'b0, 16'd0);
      @(negedge clk);
      clr     = 1'b1;
      start   = 1'b1;
      product = 16'd1234;
      @(negedge clk);
      clr   = 1'b0;
      start = 1'b0;
      check_reset_state("t6_clr_start");
      @(negedge clk);
      chk("t6_clr_idle_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
